// File: rtl/rvsteel_bus_initiator_pkg.sv
// Shared RISC-V Steel IO bus constants used by the initiator, the peripherals and the interconnect.
package rvsteel_bus_initiator_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_STRB_WIDTH = BUS_DATA_WIDTH / 8;

    typedef logic [BUS_DATA_WIDTH-1:0] bus_data_t;
    typedef logic [BUS_STRB_WIDTH-1:0] bus_strb_t;

endpackage

// File: rtl/rvsteel_bus_initiator.sv
// Bus initiator: turns a valid/ready command stream into single IO bus transactions
// and returns read data or a timeout error on a valid/ready response stream.
module rvsteel_bus_initiator
    import rvsteel_bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  bus_data_t             cmd_wdata,
    input  bus_strb_t             cmd_strobe,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output bus_data_t             rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] rw_address,
    input  bus_data_t             read_data,
    output logic                  read_request,
    input  logic                  read_response,
    output bus_data_t             write_data,
    output bus_strb_t             write_strobe,
    output logic                  write_request,
    input  logic                  write_response
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A zero timeout still needs a one-bit counter so the vector stays legal.
    localparam bit              TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam int              CNT_W       = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    bus_data_t               wdata_q, wdata_d;
    bus_strb_t               strobe_q, strobe_d;
    logic                    is_write_q, is_write_d;
    logic                    rd_req_q, rd_req_d;
    logic                    wr_req_q, wr_req_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_error_q, rsp_error_d;
    bus_data_t               rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    bus_rsp;
    logic [CNT_W-1:0]        cnt_inc;

    // Only the response type matching the outstanding command counts.
    assign bus_rsp = is_write_q ? write_response : read_response;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strobe_d    = strobe_q;
        is_write_d  = is_write_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_address;
                    wdata_d    = cmd_wdata;
                    strobe_d   = cmd_strobe;
                    is_write_d = cmd_write;
                    rd_req_d   = ~cmd_write;
                    wr_req_d   = cmd_write;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle takes priority over the error.
                if (bus_rsp) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = is_write_q ? '0 : read_data;
                    state_d     = RESP;
                end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_LIM)) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strobe_q    <= '0;
            is_write_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strobe_q    <= strobe_d;
            is_write_q  <= is_write_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rw_address    = addr_q;
    assign write_data    = wdata_q;
    assign write_strobe  = strobe_q;
    assign read_request  = rd_req_q;
    assign write_request = wr_req_q;

endmodule
